// File: rtl/voice_scheduler_pkg.sv
// rtl/voice_scheduler_pkg.sv - shared types and constants for the voice scheduler
// Contents: scheduler state encoding, metadata bit positions, default widths,
// and the note code reserved for rests.
package voice_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    localparam int META_CHORD = 0;
    localparam int DEF_NOTE_W = 6;
    localparam int DEF_DUR_W  = 6;
    localparam int NOTE_REST  = 0;

endpackage

// File: rtl/voice_scheduler_if.sv
// rtl/voice_scheduler_if.sv - reader-to-scheduler note handshake
// Signals: new_note (pulse), note, duration, metadata (bit 0 = chord) from the
// reader; note_done (pulse) back to the reader.
// Modports: master = song reader, slave = voice_scheduler.
interface voice_scheduler_if #(
    parameter int NOTE_W = voice_scheduler_pkg::DEF_NOTE_W,
    parameter int DUR_W  = voice_scheduler_pkg::DEF_DUR_W
);
    logic              new_note;
    logic [NOTE_W-1:0] note;
    logic [DUR_W-1:0]  duration;
    logic [2:0]        metadata;
    logic              note_done;

    modport master (output new_note, note, duration, metadata, input note_done);
    modport slave  (input new_note, note, duration, metadata, output note_done);
endinterface

// File: rtl/voice_scheduler_slot.sv
// rtl/voice_scheduler_slot.sv - one note-player voice: beat counter and note register
// Ports: clk, reset (async active-low), flush (sync clear), dec (accepted beat),
// load/load_note/load_dur (start a note), rem (remaining beats), note_q (held
// note code), load_pulse (registered start pulse), free (rem == 0).
module voice_slot #(
    parameter int NOTE_W = 6,
    parameter int DUR_W  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              dec,
    input  logic              load,
    input  logic [NOTE_W-1:0] load_note,
    input  logic [DUR_W-1:0]  load_dur,
    output logic [DUR_W-1:0]  rem,
    output logic [NOTE_W-1:0] note_q,
    output logic              load_pulse,
    output logic              free
);
    // A load wins over a coincident beat: a fresh or stolen voice starts with
    // its full duration.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem        <= '0;
            note_q     <= '0;
            load_pulse <= 1'b0;
        end else if (flush) begin
            rem        <= '0;
            note_q     <= '0;
            load_pulse <= 1'b0;
        end else begin
            load_pulse <= load;
            if (load) begin
                rem    <= load_dur;
                note_q <= load_note;
            end else if (dec && rem != '0) begin
                rem <= rem - DUR_W'(1);
            end
        end
    end

    assign free = (rem == '0);
endmodule

// File: rtl/voice_scheduler.sv
// rtl/voice_scheduler.sv - assigns reader notes to voices and paces the reader
// Ports: clk, reset (async active-low), play, flush, beat, rd (slave side of
// the note handshake), voice_load, voice_note (voice i at [i*NOTE_W +: NOTE_W]),
// voice_active, busy.
module voice_scheduler
    import voice_scheduler_pkg::*;
#(
    parameter int NUM_VOICES = 3,
    parameter int NOTE_W     = DEF_NOTE_W,
    parameter int DUR_W      = DEF_DUR_W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         play,
    input  logic                         flush,
    input  logic                         beat,
    voice_scheduler_if.slave             rd,
    output logic [NUM_VOICES-1:0]        voice_load,
    output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
    output logic [NUM_VOICES-1:0]        voice_active,
    output logic                         busy
);
    localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    state_t            state, state_nx;
    logic [DUR_W-1:0]  wait_cnt, wait_nx;
    logic              note_done_q;
    logic              play_q;
    logic              tick;
    logic              accept;
    logic              do_load;
    logic [IDX_W-1:0]  sel_idx;
    logic              found_free;
    logic [DUR_W-1:0]  best_rem;
    logic [DUR_W-1:0]  rem [NUM_VOICES];
    logic [NUM_VOICES-1:0] free;
    logic              unused_meta;

    assign unused_meta = ^rd.metadata[2:1];

    assign tick    = beat & play;
    assign accept  = (state == ST_IDLE) && rd.new_note && play;
    assign do_load = accept && (rd.note != NOTE_W'(NOTE_REST)) && (rd.duration != '0);

    // Lowest-index free voice; otherwise steal the voice closest to finishing
    // (strict < keeps the lowest index on ties).
    always_comb begin
        found_free = 1'b0;
        sel_idx    = '0;
        best_rem   = rem[0];
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (!found_free && free[i]) begin
                found_free = 1'b1;
                sel_idx    = IDX_W'(i);
            end
        end
        if (!found_free) begin
            for (int i = 1; i < NUM_VOICES; i++) begin
                if (rem[i] < best_rem) begin
                    best_rem = rem[i];
                    sel_idx  = IDX_W'(i);
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
        logic load_g;
        assign load_g = do_load && (sel_idx == IDX_W'(g));

        voice_slot #(.NOTE_W(NOTE_W), .DUR_W(DUR_W)) u_slot (
            .clk        (clk),
            .reset      (reset),
            .flush      (flush),
            .dec        (tick),
            .load       (load_g),
            .load_note  (rd.note),
            .load_dur   (rd.duration),
            .rem        (rem[g]),
            .note_q     (voice_note[g*NOTE_W +: NOTE_W]),
            .load_pulse (voice_load[g]),
            .free       (free[g])
        );

        assign voice_active[g] = !free[g] && play_q;
    end

    always_comb begin
        state_nx = state;
        wait_nx  = wait_cnt;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (rd.metadata[META_CHORD] || rd.duration == '0) begin
                        state_nx = ST_ACK;
                    end else begin
                        state_nx = ST_WAIT;
                        wait_nx  = rd.duration;
                    end
                end
            end
            ST_WAIT: begin
                if (tick && wait_cnt != '0) begin
                    wait_nx = wait_cnt - DUR_W'(1);
                    if (wait_cnt == DUR_W'(1)) state_nx = ST_ACK;
                end
            end
            ST_ACK:  state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            wait_cnt    <= '0;
            note_done_q <= 1'b0;
            play_q      <= 1'b0;
        end else begin
            play_q <= play;
            if (flush) begin
                state       <= ST_IDLE;
                wait_cnt    <= '0;
                note_done_q <= 1'b0;
            end else begin
                state       <= state_nx;
                wait_cnt    <= wait_nx;
                note_done_q <= (state == ST_ACK);
            end
        end
    end

    assign rd.note_done = note_done_q;
    assign busy         = (state != ST_IDLE);
endmodule

// File: tb/tb_voice_scheduler.sv
// tb/tb_voice_scheduler.sv - directed self-checking bench for voice_scheduler
module tb_voice_scheduler;
    logic        clk = 1'b0;
    logic        reset;
    logic        play;
    logic        flush;
    logic        beat;
    logic [2:0]  voice_load;
    logic [17:0] voice_note;
    logic [2:0]  voice_active;
    logic        busy;
    int          checks = 0;
    int          failures = 0;

    voice_scheduler_if #(.NOTE_W(6), .DUR_W(6)) rd ();

    voice_scheduler #(.NUM_VOICES(3), .NOTE_W(6), .DUR_W(6)) dut (
        .clk          (clk),
        .reset        (reset),
        .play         (play),
        .flush        (flush),
        .beat         (beat),
        .rd           (rd),
        .voice_load   (voice_load),
        .voice_note   (voice_note),
        .voice_active (voice_active),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a note for one cycle; returns just after the accepting edge.
    task automatic issue(input logic [5:0] n, input logic [5:0] d, input logic chord);
        rd.new_note = 1'b1;
        rd.note     = n;
        rd.duration = d;
        rd.metadata = {2'b00, chord};
        cyc();
        rd.new_note = 1'b0;
    endtask

    task automatic give_beat();
        beat = 1'b1;
        cyc();
        beat = 1'b0;
    endtask

    initial begin
        reset = 1'b0; play = 1'b1; flush = 1'b0; beat = 1'b0;
        rd.new_note = 1'b0; rd.note = '0; rd.duration = '0; rd.metadata = '0;
        cyc(); cyc();
        chk("rst_note_done", {31'd0, rd.note_done}, 32'd0);
        chk("rst_voice_load", {29'd0, voice_load}, 32'd0);
        chk("rst_voice_note", {14'd0, voice_note}, 32'd0);
        chk("rst_active", {29'd0, voice_active}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        cyc();

        // Timed note: 12, 3 beats, beats every 4 cycles
        issue(6'd12, 6'd3, 1'b0);
        chk("t1_load", {29'd0, voice_load}, 32'd1);
        chk("t1_note", {26'd0, voice_note[5:0]}, 32'd12);
        chk("t1_active", {29'd0, voice_active}, 32'd1);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        cyc();
        chk("t1_load_pulse", {29'd0, voice_load}, 32'd0);
        give_beat(); cyc(); cyc(); cyc();
        give_beat(); cyc(); cyc(); cyc();
        chk("t1_done_early", {31'd0, rd.note_done}, 32'd0);
        give_beat();
        chk("t1_active_off", {29'd0, voice_active}, 32'd0);
        chk("t1_done_b3p1", {31'd0, rd.note_done}, 32'd0);
        cyc();
        chk("t1_done_b3p2", {31'd0, rd.note_done}, 32'd1);
        chk("t1_idle", {31'd0, busy}, 32'd0);
        cyc();
        chk("t1_done_once", {31'd0, rd.note_done}, 32'd0);

        // Chord: 12, 16, 19 to voices 0, 1, 2
        issue(6'd12, 6'd4, 1'b1);
        chk("c1_load", {29'd0, voice_load}, 32'd1);
        chk("c1_done_n1", {31'd0, rd.note_done}, 32'd0);
        cyc();
        chk("c1_done_n2", {31'd0, rd.note_done}, 32'd1);
        issue(6'd16, 6'd4, 1'b1);
        chk("c2_load", {29'd0, voice_load}, 32'd2);
        chk("c2_note", {26'd0, voice_note[11:6]}, 32'd16);
        cyc();
        chk("c2_done", {31'd0, rd.note_done}, 32'd1);
        issue(6'd19, 6'd4, 1'b1);
        chk("c3_load", {29'd0, voice_load}, 32'd4);
        chk("c3_note", {26'd0, voice_note[17:12]}, 32'd19);
        cyc();
        chk("c3_done", {31'd0, rd.note_done}, 32'd1);

        // Steal: rem 4, 2, 3 then a 4th chord note takes voice 1
        flush = 1'b1; cyc(); flush = 1'b0;
        chk("s_flush_active", {29'd0, voice_active}, 32'd0);
        issue(6'd1, 6'd4, 1'b1); cyc();
        issue(6'd2, 6'd2, 1'b1); cyc();
        issue(6'd3, 6'd3, 1'b1); cyc();
        issue(6'd30, 6'd5, 1'b1);
        chk("s_load", {29'd0, voice_load}, 32'd2);
        chk("s_note", {26'd0, voice_note[11:6]}, 32'd30);
        cyc();
        give_beat(); give_beat(); give_beat();
        chk("s_active_3b", {29'd0, voice_active}, 32'd3);
        give_beat();
        chk("s_active_4b", {29'd0, voice_active}, 32'd2);
        give_beat();
        chk("s_active_5b", {29'd0, voice_active}, 32'd0);

        // Rest paces the reader without loading
        issue(6'd0, 6'd2, 1'b0);
        chk("r_load", {29'd0, voice_load}, 32'd0);
        chk("r_busy", {31'd0, busy}, 32'd1);
        give_beat(); give_beat();
        chk("r_done_early", {31'd0, rd.note_done}, 32'd0);
        cyc();
        chk("r_done", {31'd0, rd.note_done}, 32'd1);

        // Zero duration: no load, done at N+2
        issue(6'd5, 6'd0, 1'b0);
        chk("z_load", {29'd0, voice_load}, 32'd0);
        cyc();
        chk("z_done", {31'd0, rd.note_done}, 32'd1);

        // Pause mid-note: counters hold across 3 ignored beats
        issue(6'd20, 6'd4, 1'b0);
        give_beat();
        play = 1'b0;
        cyc();
        chk("p_active_paused", {29'd0, voice_active}, 32'd0);
        give_beat(); give_beat(); give_beat();
        chk("p_busy", {31'd0, busy}, 32'd1);
        play = 1'b1;
        cyc();
        chk("p_active_resume", {29'd0, voice_active}, 32'd1);
        give_beat(); give_beat();
        chk("p_active_mid", {29'd0, voice_active}, 32'd1);
        give_beat();
        chk("p_active_end", {29'd0, voice_active}, 32'd0);
        chk("p_done_early", {31'd0, rd.note_done}, 32'd0);
        cyc();
        chk("p_done", {31'd0, rd.note_done}, 32'd1);

        // Flush while waiting
        issue(6'd22, 6'd3, 1'b0);
        give_beat();
        flush = 1'b1; cyc(); flush = 1'b0;
        chk("f_busy", {31'd0, busy}, 32'd0);
        chk("f_active", {29'd0, voice_active}, 32'd0);
        chk("f_note", {14'd0, voice_note}, 32'd0);
        cyc();
        chk("f_no_done", {31'd0, rd.note_done}, 32'd0);

        // new_note during WAIT is ignored
        issue(6'd10, 6'd2, 1'b0);
        cyc();
        issue(6'd40, 6'd5, 1'b0);
        chk("w_ign_load", {29'd0, voice_load}, 32'd0);
        chk("w_ign_note", {26'd0, voice_note[11:6]}, 32'd0);
        give_beat();
        chk("w_busy", {31'd0, busy}, 32'd1);
        give_beat();
        chk("w_done_early", {31'd0, rd.note_done}, 32'd0);
        cyc();
        chk("w_done", {31'd0, rd.note_done}, 32'd1);

        // Beat coincident with new_note: new voice keeps full duration
        issue(6'd10, 6'd3, 1'b1);
        cyc();
        rd.new_note = 1'b1; rd.note = 6'd11; rd.duration = 6'd2; rd.metadata = 3'b001;
        beat = 1'b1;
        cyc();
        rd.new_note = 1'b0; beat = 1'b0;
        chk("sb_load", {29'd0, voice_load}, 32'd2);
        cyc();
        give_beat();
        chk("sb_active_1b", {29'd0, voice_active}, 32'd3);
        give_beat();
        chk("sb_active_2b", {29'd0, voice_active}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/voice_scheduler.md
# voice_scheduler

Sits between the song reader and a bank of note players. It accepts notes from the reader one at a time and assigns each to a free voice, or steals a busy one when none is free. It tracks every voice's remaining beats and paces the reader by returning `note_done` either immediately (chord member) or after the note's duration has elapsed in beats.

## Interface
Parameters:
- NUM_VOICES, 3, number of note-player voices (1..8)
- NOTE_W, 6, note code width; code 0 = rest
- DUR_W, 6, duration width in beats

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- play  in  1  1 = playing; 0 = paused (beats ignored, state frozen)
- flush  in  1  synchronous clear of all voices and state (song change)
- beat  in  1  one-cycle beat pulse
- new_note  in  1  one-cycle pulse from reader; note/duration/metadata valid this cycle
- note  in  NOTE_W  note code
- duration  in  DUR_W  note length in beats
- metadata  in  3  bit 0 = CHORD; bits 2:1 reserved, ignored
- note_done  out  1  one-cycle pulse: reader may issue next note
- voice_load  out  NUM_VOICES  one-cycle pulse per voice: start note on that player
- voice_note  out  NUM_VOICES*NOTE_W  per-voice note code, voice i at bits [i*NOTE_W +: NOTE_W]
- voice_active  out  NUM_VOICES  voice remaining count != 0, gated by play
- busy  out  1  state != IDLE

## Operation
- Per voice: remaining-beat counter `rem[i]` (DUR_W) and note register. Voice i is free when `rem[i] == 0`.
- States: IDLE, WAIT, ACK.
- IDLE, new_note accepted (play=1):
  - Voice load: if note != 0 and duration != 0, load a voice. Choose the lowest-index free voice. If none is free, steal the voice with the smallest `rem`, lowest index on tie. Set `rem = duration`, latch note, and pulse `voice_load[i]` in the next cycle.
  - Next state: if CHORD=1 or duration=0, go to ACK. Otherwise go to WAIT and load `wait_cnt = duration`.
  - Rests (note=0) are never loaded but pace the reader normally.
- WAIT: on beat & play, `wait_cnt` decrements. When the decrement takes it from 1 to 0, go to ACK.
- ACK: `note_done = 1` for exactly one cycle, then go to IDLE.
- new_note arriving in WAIT or ACK is a protocol violation and is ignored (no load, no state change). new_note with play=0 is also ignored.
- beat & play: every nonzero `rem[i]` decrements by 1. beat with play=0 is ignored.
- Simultaneous beat and new_note in IDLE: existing counters decrement first. The newly loaded voice gets the full duration, not decremented. A stolen voice is overwritten rather than decremented.
- flush (any state, priority over everything except reset): all `rem` = 0, notes = 0, `wait_cnt` = 0, state = IDLE, no pulses next cycle.
- Arithmetic: counters are unsigned DUR_W. Counters never decrement below 0, and there is no wrap.

## Timing
- All outputs are registered.
- Reset values: note_done 0, voice_load 0, voice_note 0, voice_active 0, busy 0, all counters 0, state IDLE.
- new_note in cycle N:
  - `voice_load[i]` high in N+1.
  - `voice_note` updated in N+1.
  - `voice_active[i]` high from N+1.
- Chord or zero-duration note at N: note_done high in N+2 (state ACK in N+1, output registered).
- Timed note at N with duration D: note_done high 2 cycles after the D-th accepted beat following N.
- A beat coincident with new_note does not count toward that note's `wait_cnt`.
- Pause: counters hold, voice_active drops to 0 the cycle after play falls, and resumes from the held counts.
- Reset is asynchronous assert and synchronous deassert (external synchronizer). Mid-note reset clears everything immediately.

## Structure
- Shared package holds:
  - state encoding (IDLE/WAIT/ACK)
  - META_CHORD = 0
  - default NOTE_W/DUR_W
  - NOTE_REST = 0
- Sub-module `voice_slot`, one per voice, holds the counter, note register, load pulse, and free flag.
- The top level contains the FSM, wait counter, free-voice priority encoder, and smallest-`rem` steal comparator.

## Test plan
- Timed note: note=12, dur=3, CHORD=0, beats every 4 cycles → voice 0 loads 12; note_done 2 cycles after the 3rd beat; voice_active[0] falls after the 3rd beat.
- Chord: notes 12, 16, 19 (CHORD=1, dur=4) → voices 0, 1, 2 load in order; each note_done arrives 2 cycles after its new_note.
- Steal: four chord notes with voice rem = 4, 2, 3 → 4th note overwrites voice 1 (rem 2) and sets rem = its duration.
- Rest and zero duration: note=0, dur=2 → no voice_load, note_done after 2 beats. dur=0 → no load, note_done at N+2.
- Pause and flush: play=0 across 3 beats mid-note → counters unchanged, voice_active=0. Resume then finishes. flush in WAIT → all cleared, IDLE, no note_done.
- new_note during WAIT → ignored, with no voice_load and no change to wait_cnt. Simultaneous beat and new_note → new voice keeps full duration.
